squash_input_conditioner: RTL and testbench
===========================================

Name: squash_input_conditioner

Overview:
- Sits directly upstream of the solo_squash game core.
- Takes the four raw, bouncy, asynchronous active-low push-buttons (up, down, pause, new game). Produces clean, clk-synchronous, active-low control signals that drive the core's up_key_n, down_key_n, pause_n and new_game_n inputs.
- Pause becomes a latched toggle. New game becomes a single-cycle strobe.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable clk cycles needed to accept a level change (10 ms at 25 MHz). Legal range is 2..2^CNT_W-1.
- CNT_W, 18, width of each per-channel debounce counter.

Ports:
- clk  input  1  25 MHz pixel clock.
- reset  input  1  synchronous, active-high reset.
- btn_up_n  input  1  raw up button, active low, asynchronous.
- btn_down_n  input  1  raw down button, active low, asynchronous.
- btn_pause_n  input  1  raw pause button, active low, asynchronous.
- btn_new_game_n  input  1  raw new-game button, active low, asynchronous.
- up_key_n  output  1  debounced up level, active low.
- down_key_n  output  1  debounced down level, active low.
- pause_n  output  1  latched run/pause state; 0 = paused.
- new_game_n  output  1  one-cycle active-low new-game strobe.

Behaviour:
- Clock and reset: reset is reset, synchronous, active-high; clock is clk. Every flop is reset; there are no asynchronous paths.
- Reset values:
  - all outputs = 1;
  - sync flops = 1;
  - debounced levels d = 1 (released);
  - counters = 0;
  - pause state = running.
- Synchroniser: each button passes through a 2-FF synchroniser (s1 then s2).
- Debounce, per channel (4 identical instances):
  - If s2 == d, cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1, then d <= s2 and cnt <= 0.
  - Else, cnt <= cnt+1.
- Latency: a raw change first captured by s1 at edge k appears on d at edge k+1+DEBOUNCE_CYCLES, provided it is held throughout.
- Glitch rejection:
  - Any excursion lasting fewer than DEBOUNCE_CYCLES cycles at s2 never changes d.
  - An excursion returning before terminal count clears cnt to 0; there is no accumulation across glitches.
- up_key_n = d_up and down_key_n = d_down, each driven from the flop directly.
  - No arbitration: both may be low at once; the core gives down priority.
- Press event: a press on a channel is defined as the edge at which d goes 1->0. Releases (0->1) generate no event.
- new_game_n: driven 0 for exactly one cycle, at the edge following the new-game press event, then returns to 1.
  - Holding the button produces no further strobes.
  - A new strobe requires a release to be accepted, then a new press.
- pause_n:
  - Toggles at the edge following a pause press event.
  - Held button means one toggle only.
- Simultaneous events:
  - A new-game press event forces pause_n <= 1 (running) on that edge. This overrides any pause toggle on the same edge.
  - A pause press event on the same edge is discarded.
- Reset mid-debounce: all counters clear and d returns to 1, even if a button is physically held.
  - A held button after reset is re-accepted as a fresh press after the normal latency.
  - That press therefore generates a strobe or toggle.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Channels are fully independent: no shared counters and no cross-channel timing coupling.

Test Plan (bench uses DEBOUNCE_CYCLES=4, CNT_W=3):
1. Reset then idle: hold reset for 3 cycles with all buttons at 1 -> all outputs are 1 throughout and after release.
2. Clean press: btn_up_n goes 0 before edge k and is held -> up_key_n goes 0 at edge k+5. Release it -> up_key_n returns to 1 at release edge+5.
3. Bounce: btn_down_n low for 3 cycles, high for 1, low for 3, then high -> down_key_n stays 1 throughout. The same pulse held for 4 cycles -> down_key_n gives a single 4-cycle-wide low.
4. Pause toggle: press and hold btn_pause_n for 20 cycles -> pause_n goes 0 exactly once, 6 edges after first capture, and stays 0. Release, then press again -> pause_n returns to 1.
5. New game:
   - while paused (pause_n=0), press btn_new_game_n and hold for 30 cycles -> new_game_n is 0 for exactly 1 cycle, pause_n becomes 1 on that same edge, and no second strobe occurs;
   - press pause and new-game so both debounced edges coincide -> pause_n = 1.
6. Reset mid-operation: hold btn_up_n low and assert reset during debounce count 2 -> after reset up_key_n stays 1 for 5 more edges, then goes 0.

Source files
------------

// File: rtl/squash_input_conditioner_if.sv
// Button-side and game-core-side signals of the squash input conditioner.
// The master drives raw buttons; the slave returns the conditioned controls.
interface squash_input_conditioner_if;
    logic btn_up_n;
    logic btn_down_n;
    logic btn_pause_n;
    logic btn_new_game_n;
    logic up_key_n;
    logic down_key_n;
    logic pause_n;
    logic new_game_n;

    modport master (
        output btn_up_n,
        output btn_down_n,
        output btn_pause_n,
        output btn_new_game_n,
        input  up_key_n,
        input  down_key_n,
        input  pause_n,
        input  new_game_n
    );

    modport slave (
        input  btn_up_n,
        input  btn_down_n,
        input  btn_pause_n,
        input  btn_new_game_n,
        output up_key_n,
        output down_key_n,
        output pause_n,
        output new_game_n
    );
endinterface

// File: rtl/squash_input_conditioner.sv
// Synchronises and debounces the four raw squash buttons, then derives a latched
// pause toggle and a one-cycle new-game strobe. DEBOUNCE_CYCLES must be 2..2^CNT_W-1.
module squash_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    squash_input_conditioner_if.slave  bus
);

    localparam int unsigned N_CH     = 4;
    localparam int unsigned CH_UP    = 0;
    localparam int unsigned CH_DOWN  = 1;
    localparam int unsigned CH_PAUSE = 2;
    localparam int unsigned CH_NEW   = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0] raw_n;
    logic [N_CH-1:0] db;

    assign raw_n = {bus.btn_new_game_n, bus.btn_pause_n, bus.btn_down_n, bus.btn_up_n};

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic             s1_q, s1_d;
        logic             s2_q, s2_d;
        logic             db_q, db_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;

        // Level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_comb begin
            s1_d  = raw_n[g];
            s2_d  = s1_q;
            db_d  = db_q;
            cnt_d = '0;
            if (s2_q != db_q) begin
                if (cnt_q == CNT_LAST) begin
                    db_d = s2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_q  <= 1'b1;
                s2_q  <= 1'b1;
                db_q  <= 1'b1;
                cnt_q <= '0;
            end else begin
                s1_q  <= s1_d;
                s2_q  <= s2_d;
                db_q  <= db_d;
                cnt_q <= cnt_d;
            end
        end

        assign db[g] = db_q;
    end

    logic pause_prev_q, pause_prev_d;
    logic new_prev_q,   new_prev_d;
    logic pause_n_q,    pause_n_d;
    logic new_game_n_q, new_game_n_d;
    logic pause_press;
    logic new_press;

    // Press = debounced 1->0; new game wins over a coincident pause press.
    always_comb begin
        pause_press  = pause_prev_q & ~db[CH_PAUSE];
        new_press    = new_prev_q & ~db[CH_NEW];
        pause_prev_d = db[CH_PAUSE];
        new_prev_d   = db[CH_NEW];
        new_game_n_d = ~new_press;
        pause_n_d    = pause_n_q;
        if (new_press) begin
            pause_n_d = 1'b1;
        end else if (pause_press) begin
            pause_n_d = ~pause_n_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pause_prev_q <= 1'b1;
            new_prev_q   <= 1'b1;
            pause_n_q    <= 1'b1;
            new_game_n_q <= 1'b1;
        end else begin
            pause_prev_q <= pause_prev_d;
            new_prev_q   <= new_prev_d;
            pause_n_q    <= pause_n_d;
            new_game_n_q <= new_game_n_d;
        end
    end

    assign bus.up_key_n   = db[CH_UP];
    assign bus.down_key_n = db[CH_DOWN];
    assign bus.pause_n    = pause_n_q;
    assign bus.new_game_n = new_game_n_q;

endmodule

// File: tb/tb_squash_input_conditioner.sv
// Directed bench for squash_input_conditioner with DEBOUNCE_CYCLES=4, CNT_W=3.
module tb_squash_input_conditioner;

    localparam int unsigned DEB = 4;
    localparam int unsigned CW  = 3;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    squash_input_conditioner_if bus ();

    squash_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.btn_up_n = 1'b1;
        bus.btn_down_n = 1'b1;
        bus.btn_pause_n = 1'b1;
        bus.btn_new_game_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.up_key_n, bus.down_key_n, bus.pause_n, bus.new_game_n} !== 4'b1111)
                $display("FAIL reset_hold cyc%0d outs=%b exp=1111", i,
                         {bus.up_key_n, bus.down_key_n, bus.pause_n, bus.new_game_n});
            else passes++;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.up_key_n, bus.down_key_n, bus.pause_n, bus.new_game_n} !== 4'b1111)
                $display("FAIL reset_idle cyc%0d outs=%b exp=1111", i,
                         {bus.up_key_n, bus.down_key_n, bus.pause_n, bus.new_game_n});
            else passes++;
        end
    endtask

    task automatic test_clean_press();
        logic exp;
        bus.btn_up_n = 1'b0;
        for (int i = 0; i <= 7; i++) begin
            tick();
            exp = (i >= 5) ? 1'b0 : 1'b1;
            checks++;
            if (bus.up_key_n !== exp)
                $display("FAIL press_up i=%0d up_key_n=%b exp=%b", i, bus.up_key_n, exp);
            else passes++;
        end
        checks++;
        if ({bus.down_key_n, bus.pause_n, bus.new_game_n} !== 3'b111)
            $display("FAIL press_up_isolation others=%b exp=111",
                     {bus.down_key_n, bus.pause_n, bus.new_game_n});
        else passes++;
        bus.btn_up_n = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            tick();
            exp = (i >= 5) ? 1'b1 : 1'b0;
            checks++;
            if (bus.up_key_n !== exp)
                $display("FAIL release_up i=%0d up_key_n=%b exp=%b", i, bus.up_key_n, exp);
            else passes++;
        end
    endtask

    task automatic test_bounce();
        logic pat [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int lows = 0;
        int first = -1;
        int last = -1;
        for (int i = 0; i < 15; i++) begin
            bus.btn_down_n = (i < 7) ? pat[i] : 1'b1;
            tick();
            checks++;
            if (bus.down_key_n !== 1'b1)
                $display("FAIL bounce_reject i=%0d down_key_n=%b exp=1", i, bus.down_key_n);
            else passes++;
        end
        for (int i = 0; i < 14; i++) begin
            bus.btn_down_n = (i < 4) ? 1'b0 : 1'b1;
            tick();
            if (bus.down_key_n === 1'b0) begin
                lows++;
                if (first < 0) first = i;
                last = i;
            end
        end
        checks++;
        if (lows != 4) $display("FAIL pulse4_width lows=%0d exp=4", lows);
        else passes++;
        checks++;
        if (first != 5) $display("FAIL pulse4_first first=%0d exp=5", first);
        else passes++;
        checks++;
        if (last != 8) $display("FAIL pulse4_last last=%0d exp=8", last);
        else passes++;
    endtask

    task automatic test_pause_toggle();
        logic exp;
        bus.btn_pause_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp = (i >= 6) ? 1'b0 : 1'b1;
            checks++;
            if (bus.pause_n !== exp)
                $display("FAIL pause_hold i=%0d pause_n=%b exp=%b", i, bus.pause_n, exp);
            else passes++;
        end
        bus.btn_pause_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.pause_n !== 1'b0)
                $display("FAIL pause_release i=%0d pause_n=%b exp=0", i, bus.pause_n);
            else passes++;
        end
        bus.btn_pause_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp = (i >= 6) ? 1'b1 : 1'b0;
            checks++;
            if (bus.pause_n !== exp)
                $display("FAIL pause_again i=%0d pause_n=%b exp=%b", i, bus.pause_n, exp);
            else passes++;
        end
        bus.btn_pause_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_new_game();
        logic [1:0] exp;
        int strobes = 0;
        bus.btn_pause_n = 1'b0;
        repeat (8) tick();
        bus.btn_pause_n = 1'b1;
        repeat (8) tick();
        checks++;
        if (bus.pause_n !== 1'b0) $display("FAIL ng_setup_paused pause_n=%b exp=0", bus.pause_n);
        else passes++;
        bus.btn_new_game_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            exp = {(i == 6) ? 1'b0 : 1'b1, (i >= 6) ? 1'b1 : 1'b0};
            if (bus.new_game_n === 1'b0) strobes++;
            checks++;
            if ({bus.new_game_n, bus.pause_n} !== exp)
                $display("FAIL ng_hold i=%0d {new_game_n,pause_n}=%b exp=%b", i,
                         {bus.new_game_n, bus.pause_n}, exp);
            else passes++;
        end
        checks++;
        if (strobes != 1) $display("FAIL ng_strobe_count strobes=%0d exp=1", strobes);
        else passes++;
        bus.btn_new_game_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.new_game_n !== 1'b1)
                $display("FAIL ng_release i=%0d new_game_n=%b exp=1", i, bus.new_game_n);
            else passes++;
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp;
        bus.btn_pause_n = 1'b0;
        bus.btn_new_game_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp = {(i == 6) ? 1'b0 : 1'b1, 1'b1};
            checks++;
            if ({bus.new_game_n, bus.pause_n} !== exp)
                $display("FAIL simul i=%0d {new_game_n,pause_n}=%b exp=%b", i,
                         {bus.new_game_n, bus.pause_n}, exp);
            else passes++;
        end
        bus.btn_pause_n = 1'b1;
        bus.btn_new_game_n = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp;
        bus.btn_up_n = 1'b0;
        bus.btn_pause_n = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        checks++;
        if ({bus.up_key_n, bus.pause_n} !== 2'b11)
            $display("FAIL reset_mid_hold {up_key_n,pause_n}=%b exp=11", {bus.up_key_n, bus.pause_n});
        else passes++;
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            exp = {(i >= 5) ? 1'b0 : 1'b1, (i >= 6) ? 1'b0 : 1'b1};
            checks++;
            if ({bus.up_key_n, bus.pause_n} !== exp)
                $display("FAIL reset_mid_reaccept i=%0d {up_key_n,pause_n}=%b exp=%b", i,
                         {bus.up_key_n, bus.pause_n}, exp);
            else passes++;
        end
        bus.btn_up_n = 1'b1;
        bus.btn_pause_n = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_pause_toggle();
        test_new_game();
        test_simultaneous();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
